led_pattern_gen: RTL and testbench
==================================

// Module: led_pattern_gen
// PURPOSE
//  Parametrised successor to the 4-LED flow block: drives LED_NUM LEDs with a selectable pattern
//  (rotate left, rotate right, ping-pong, blink-all), advanced once per programmable period.
//  Sits between board I/O and control logic. Adds run/freeze enable, step strobe, output polarity.
// PARAMETERS
//  LED_NUM    4               number of LEDs, >= 2
//  CNT_MAX    25'd24_999_999  step period = CNT_MAX+1 sys_clk cycles; counter runs 0..CNT_MAX
//  ACTIVE_LOW 1               1: led_out = ~pattern (LED lit on 0); 0: led_out = pattern
//  CNT_W      derived localparam $clog2(CNT_MAX+1); not overridable
// PORTS
//  sys_clk     in   1        system clock; all logic on rising edge
//  sys_rst     in   1        reset; synchronous, active-high
//  en          in   1        1: run; 0: freeze counter and pattern
//  mode        in   2        00 rotate-left, 01 rotate-right, 10 ping-pong, 11 blink-all
//  led_out     out  LED_NUM  LED drive after polarity (and PWM when enabled)
//  step_pulse  out  1        one-cycle strobe, high in the first cycle a new pattern is shown
// BEHAVIOUR
//  - Reset (sys_rst=1 at edge): count=0, pattern={0..0,1}, dir=up, mode_q=mode, step_pulse=0;
//    led_out = ACTIVE_LOW ? ~{0..01} : {0..01} from the cycle after the reset edge.
//  - All state registered; led_out/step_pulse are registered, no comb path from inputs.
//  - Step: en=1 and count==CNT_MAX -> count<=0, pattern advances, step_pulse<=1 (one cycle).
//    Otherwise en=1 -> count<=count+1, step_pulse<=0. en=0 -> count, pattern, dir hold; pulse=0.
//  - mode sampled into mode_q every cycle (even with en=0). mode!=mode_q -> re-init next edge:
//    count<=0, dir<=up, step_pulse<=0, pattern <= all-ones for 11, else {0..01}. No step that cycle.
//  - Rotate-left: bit i -> i+1, MSB wraps to LSB. Rotate-right: mirror; LSB wraps to MSB.
//  - Ping-pong: dir up shifts left until MSB set, then dir flips to down; down shifts right until
//    LSB set, then flips up. End LEDs shown once per turn (4 LEDs: 1,2,4,8,4,2,1,2,...).
//    LED_NUM=2: alternates 01,10.
//  - Blink-all: each step toggles pattern between all-ones and all-zeros.
//  - Corrupt state: in modes 00-10 a non-one-hot pattern reloads {0..01} (dir=up) at next step;
//    in mode 11 any value other than all-ones/all-zeros reloads all-ones at next step.
//  - Priority per edge: sys_rst > mode change > step > count increment.
// CONFIGURATION
//  Macro LED_PWM_DIM_EN:
//  - defined: adds parameter PWM_BITS (default 4) and input port duty[PWM_BITS-1:0]; a
//    free-running PWM_BITS counter (reset 0, runs regardless of en) gates lit LEDs:
//    LED lit only while pwm_cnt < duty. duty=0 -> all dark; duty=2^PWM_BITS-1 -> (2^PWM_BITS-1)
//    of every 2^PWM_BITS cycles. Unlit LEDs stay off. Polarity applied after gating.
//  - undefined: no duty port, no PWM counter; lit LEDs driven continuously.
//  Pattern, counter, step_pulse timing identical in both builds.
// STRUCTURE
//  - Package led_pkg: mode encodings MODE_ROT_L=2'b00, MODE_ROT_R=2'b01, MODE_PING=2'b10,
//    MODE_BLINK=2'b11; dir encodings DIR_UP/DIR_DOWN.
//  - Sub-module led_tick_gen: period counter (CNT_MAX, en, sys_rst, clear) -> tick at count==CNT_MAX.
//  - Top: mode register, pattern/dir state machine, polarity and optional PWM output stage.
// TESTING  (CNT_MAX=3, LED_NUM=4, ACTIVE_LOW=1 unless noted)
//  1 sys_rst=1 for 2 cycles, mode=00, en=1 -> led_out=4'b1110, pulse=0; 4 cycles after release
//    -> led_out=4'b1101 with step_pulse=1 for exactly one cycle.
//  2 mode=00 for 5 steps -> 0001,0010,0100,1000,0001 (pattern); mode=01 -> 0001,1000,0100,0010.
//  3 mode=10 for 8 steps -> 0001,0010,0100,1000,0100,0010,0001,0010.
//  4 Switch to mode=11 mid-period -> pattern=1111 next edge, count restarts, no pulse;
//    then 0000,1111 alternating every 4 cycles.
//  5 en=0 for 10 cycles at count=1 -> led_out and count frozen, no pulse; en=1 -> step
//    after the 2 remaining count cycles (count 2 then 3).
//  6 sys_rst=1 mid-ping-pong (dir=down) -> pattern=0001, dir=up; LED_PWM_DIM_EN, duty=8 ->
//    lit LED on 8 of every 16 cycles; duty=0 -> led_out=4'b1111.

Source files
------------

// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes and ping-pong direction.
package led_pkg;

  localparam logic [1:0] MODE_ROT_L = 2'b00;
  localparam logic [1:0] MODE_ROT_R = 2'b01;
  localparam logic [1:0] MODE_PING  = 2'b10;
  localparam logic [1:0] MODE_BLINK = 2'b11;

  localparam logic [0:0] DIR_UP   = 1'b0;
  localparam logic [0:0] DIR_DOWN = 1'b1;

endpackage

// File: rtl/led_tick_gen.sv
// Step-period counter: runs 0..CNT_MAX while enabled, tick_c marks the terminal count.
module led_tick_gen
  import led_pkg::*;
#(
  parameter int unsigned CNT_MAX = 24_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic en,
  input  logic clear,
  output logic tick_c
);

  localparam int unsigned CNT_W = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

  logic [CNT_W-1:0] count;

  assign tick_c = en && (count == CNT_W'(CNT_MAX));

  // clear (mode change) outranks the wrap so a re-init always starts a full period
  always_ff @(posedge sys_clk) begin
    if (sys_rst || clear) begin
      count <= '0;
    end else if (tick_c) begin
      count <= '0;
    end else if (en) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-LED pattern generator (rotate L/R, ping-pong, blink) with run enable, step strobe,
// output polarity and, when LED_PWM_DIM_EN is defined, a PWM duty dimmer on lit LEDs.
module led_pattern_gen
  import led_pkg::*;
#(
  parameter int unsigned LED_NUM    = 4,
  parameter int unsigned CNT_MAX    = 24_999_999,
  parameter bit          ACTIVE_LOW = 1'b1
`ifdef LED_PWM_DIM_EN
  ,
  parameter int unsigned PWM_BITS   = 4
`endif
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               en,
  input  logic [1:0]         mode,
`ifdef LED_PWM_DIM_EN
  input  logic [PWM_BITS-1:0] duty,
`endif
  output logic [LED_NUM-1:0] led_out,
  output logic               step_pulse
);

  localparam logic [LED_NUM-1:0] PAT_INIT = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] PAT_ONES = {LED_NUM{1'b1}};

  logic [1:0]         mode_q;
  logic [LED_NUM-1:0] pattern;
  logic [0:0]         dir;
  logic               tick;
  logic               mode_chg;

  logic [LED_NUM-1:0] pattern_d;
  logic [0:0]         dir_d;
  logic               pulse_d;
  logic               go_up;
  logic [LED_NUM-1:0] shifted;
  logic [LED_NUM-1:0] shown;
  logic [LED_NUM-1:0] lit;
  logic [LED_NUM-1:0] led_d;

  assign mode_chg = (mode != mode_q);

  led_tick_gen #(
    .CNT_MAX (CNT_MAX)
  ) u_tick (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .en      (en),
    .clear   (mode_chg),
    .tick_c  (tick)
  );

  // next pattern/direction: mode change re-init beats a step
  always_comb begin
    pattern_d = pattern;
    dir_d     = dir;
    pulse_d   = 1'b0;
    go_up     = 1'b0;
    shifted   = pattern;
    if (mode_chg) begin
      pattern_d = (mode == MODE_BLINK) ? PAT_ONES : PAT_INIT;
      dir_d     = DIR_UP;
    end else if (tick) begin
      pulse_d = 1'b1;
      case (mode_q)
        MODE_ROT_L: begin
          if ($onehot(pattern)) begin
            pattern_d = {pattern[LED_NUM-2:0], pattern[LED_NUM-1]};
          end else begin
            pattern_d = PAT_INIT;
            dir_d     = DIR_UP;
          end
        end
        MODE_ROT_R: begin
          if ($onehot(pattern)) begin
            pattern_d = {pattern[0], pattern[LED_NUM-1:1]};
          end else begin
            pattern_d = PAT_INIT;
            dir_d     = DIR_UP;
          end
        end
        MODE_PING: begin
          if (!$onehot(pattern)) begin
            pattern_d = PAT_INIT;
            dir_d     = DIR_UP;
          end else begin
            // turn around on reaching an end so each end LED is shown once per pass
            go_up     = (dir == DIR_UP) ? !pattern[LED_NUM-1] : pattern[0];
            shifted   = go_up ? (pattern << 1) : (pattern >> 1);
            pattern_d = shifted;
            if (go_up) begin
              dir_d = shifted[LED_NUM-1] ? DIR_DOWN : DIR_UP;
            end else begin
              dir_d = shifted[0] ? DIR_UP : DIR_DOWN;
            end
          end
        end
        default: begin
          // anything but all-ones (incl. corrupt values) goes to all-ones
          pattern_d = (pattern == PAT_ONES) ? '0 : PAT_ONES;
        end
      endcase
    end
  end

  assign shown = sys_rst ? PAT_INIT : pattern_d;

`ifdef LED_PWM_DIM_EN
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] pwm_d;

  assign pwm_d = sys_rst ? '0 : pwm_cnt + PWM_BITS'(1);
  assign lit   = (pwm_d < duty) ? shown : '0;

  always_ff @(posedge sys_clk) begin
    pwm_cnt <= pwm_d;
  end
`else
  assign lit = shown;
`endif

  assign led_d = ACTIVE_LOW ? ~lit : lit;

  always_ff @(posedge sys_clk) begin
    mode_q  <= mode;
    led_out <= led_d;
    if (sys_rst) begin
      pattern    <= PAT_INIT;
      dir        <= DIR_UP;
      step_pulse <= 1'b0;
    end else begin
      pattern    <= pattern_d;
      dir        <= dir_d;
      step_pulse <= pulse_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen: per-edge vector table plus freeze, reset and PWM sequences.
module tb_led_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [3:0] led_out;
  logic       step_pulse;

  logic       rst2;
  logic       en2;
  logic [1:0] mode2;
  logic [1:0] led2;
  logic       pulse2;

  int total = 0;
  int bad   = 0;

`ifdef LED_PWM_DIM_EN
  logic [3:0] duty;
  logic       duty2;
  int         tb_pwm = 0;
`endif

  always #5 clk = ~clk;

  led_pattern_gen #(
    .LED_NUM    (4),
    .CNT_MAX    (3),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk    (clk),
    .sys_rst    (rst),
    .en         (en),
    .mode       (mode),
`ifdef LED_PWM_DIM_EN
    .duty       (duty),
`endif
    .led_out    (led_out),
    .step_pulse (step_pulse)
  );

  led_pattern_gen #(
    .LED_NUM    (2),
    .CNT_MAX    (1),
    .ACTIVE_LOW (1'b0)
`ifdef LED_PWM_DIM_EN
    ,
    .PWM_BITS   (1)
`endif
  ) dut2 (
    .sys_clk    (clk),
    .sys_rst    (rst2),
    .en         (en2),
    .mode       (mode2),
`ifdef LED_PWM_DIM_EN
    .duty       (duty2),
`endif
    .led_out    (led2),
    .step_pulse (pulse2)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [3:0] pat;
    logic       pulse;
  } vec_t;

  vec_t vecs[$];

  task automatic push(input logic r, input logic e, input logic [1:0] m,
                      input logic [3:0] p, input logic pl);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.pat = p; v.pulse = pl;
    vecs.push_back(v);
  endtask

  // one full period: three counting edges holding prev, then the stepping edge
  task automatic push_step(input logic [1:0] m, input logic [3:0] prev, input logic [3:0] nxt);
    for (int k = 0; k < 3; k++) push(1'b0, 1'b1, m, prev, 1'b0);
    push(1'b0, 1'b1, m, nxt, 1'b1);
  endtask

  task automatic cyc(input logic r, input logic e, input logic [1:0] m);
    @(negedge clk);
    rst = r; en = e; mode = m;
    @(posedge clk);
    #1;
`ifdef LED_PWM_DIM_EN
    tb_pwm = r ? 0 : (tb_pwm + 1) % 16;
`endif
  endtask

  task automatic check(input string name, input logic [3:0] pat, input logic pulse);
    logic [3:0] exp_led;
`ifdef LED_PWM_DIM_EN
    exp_led = (tb_pwm < int'(duty)) ? ~pat : 4'b1111;
`else
    exp_led = ~pat;
`endif
    total++;
    if (led_out !== exp_led) begin
      bad++;
      $display("FAIL %s led_out got=%b want=%b", name, led_out, exp_led);
    end
    total++;
    if (step_pulse !== pulse) begin
      bad++;
      $display("FAIL %s step_pulse got=%b want=%b", name, step_pulse, pulse);
    end
  endtask

  task automatic step4(input string name, input logic [1:0] m,
                       input logic [3:0] prev, input logic [3:0] nxt);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, m);
      check($sformatf("%s_cnt%0d", name, k), prev, 1'b0);
    end
    cyc(1'b0, 1'b1, m);
    check($sformatf("%s_step", name), nxt, 1'b1);
  endtask

  task automatic cyc2(input logic r, input string name, input logic [1:0] exp_led,
                      input logic exp_pulse);
    @(negedge clk);
    rst2 = r;
    @(posedge clk);
    #1;
`ifndef LED_PWM_DIM_EN
    total++;
    if (led2 !== exp_led) begin
      bad++;
      $display("FAIL %s led2 got=%b want=%b", name, led2, exp_led);
    end
    total++;
    if (pulse2 !== exp_pulse) begin
      bad++;
      $display("FAIL %s pulse2 got=%b want=%b", name, pulse2, exp_pulse);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00;
    rst2 = 1'b1; en2 = 1'b1; mode2 = 2'b10;
`ifdef LED_PWM_DIM_EN
    duty = 4'd15;
    duty2 = 1'b1;
`endif

    // reset, then rotate-left from reset value
    push(1'b1, 1'b1, 2'b00, 4'b0001, 1'b0);
    push(1'b1, 1'b1, 2'b00, 4'b0001, 1'b0);
    push_step(2'b00, 4'b0001, 4'b0010);
    push_step(2'b00, 4'b0010, 4'b0100);
    push_step(2'b00, 4'b0100, 4'b1000);
    push_step(2'b00, 4'b1000, 4'b0001);
    push_step(2'b00, 4'b0001, 4'b0010);
    // rotate-right after re-init
    push(1'b0, 1'b1, 2'b01, 4'b0001, 1'b0);
    push_step(2'b01, 4'b0001, 4'b1000);
    push_step(2'b01, 4'b1000, 4'b0100);
    push_step(2'b01, 4'b0100, 4'b0010);
    push_step(2'b01, 4'b0010, 4'b0001);
    // ping-pong, eight steps
    push(1'b0, 1'b1, 2'b10, 4'b0001, 1'b0);
    push_step(2'b10, 4'b0001, 4'b0010);
    push_step(2'b10, 4'b0010, 4'b0100);
    push_step(2'b10, 4'b0100, 4'b1000);
    push_step(2'b10, 4'b1000, 4'b0100);
    push_step(2'b10, 4'b0100, 4'b0010);
    push_step(2'b10, 4'b0010, 4'b0001);
    push_step(2'b10, 4'b0001, 4'b0010);
    push_step(2'b10, 4'b0010, 4'b0100);
    // mid-period switch to blink: count restarts, no pulse on the switch edge
    push(1'b0, 1'b1, 2'b10, 4'b0100, 1'b0);
    push(1'b0, 1'b1, 2'b10, 4'b0100, 1'b0);
    push(1'b0, 1'b1, 2'b11, 4'b1111, 1'b0);
    push_step(2'b11, 4'b1111, 4'b0000);
    push_step(2'b11, 4'b0000, 4'b1111);
    push_step(2'b11, 4'b1111, 4'b0000);
    // leave blink from all-zeros
    push(1'b0, 1'b1, 2'b00, 4'b0001, 1'b0);
    push_step(2'b00, 4'b0001, 4'b0010);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].en, vecs[i].mode);
      check($sformatf("vec%0d", i), vecs[i].pat, vecs[i].pulse);
    end

    // freeze at count=1 for 10 cycles, then finish the period
    cyc(1'b1, 1'b1, 2'b00);
    check("frz_rst", 4'b0001, 1'b0);
    cyc(1'b0, 1'b1, 2'b00);
    check("frz_c1", 4'b0001, 1'b0);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0, 2'b00);
      check($sformatf("frz_hold%0d", k), 4'b0001, 1'b0);
    end
    cyc(1'b0, 1'b1, 2'b00);
    check("frz_c2", 4'b0001, 1'b0);
    cyc(1'b0, 1'b1, 2'b00);
    check("frz_c3", 4'b0001, 1'b0);
    cyc(1'b0, 1'b1, 2'b00);
    check("frz_step", 4'b0010, 1'b1);
    cyc(1'b0, 1'b1, 2'b00);
    check("frz_pulse_end", 4'b0010, 1'b0);

    // mode change still re-inits while frozen; blink then starts a full period after en=1
    cyc(1'b0, 1'b0, 2'b11);
    check("frz_chg", 4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 1'b0, 2'b11);
      check($sformatf("frz_blink_hold%0d", k), 4'b1111, 1'b0);
    end
    step4("frz_blink", 2'b11, 4'b1111, 4'b0000);

    // reset while ping-pong is heading down
    cyc(1'b0, 1'b1, 2'b10);
    check("pp_chg", 4'b0001, 1'b0);
    step4("pp1", 2'b10, 4'b0001, 4'b0010);
    step4("pp2", 2'b10, 4'b0010, 4'b0100);
    step4("pp3", 2'b10, 4'b0100, 4'b1000);
    step4("pp4", 2'b10, 4'b1000, 4'b0100);
    cyc(1'b1, 1'b1, 2'b10);
    check("pp_rst", 4'b0001, 1'b0);
    step4("pp5", 2'b10, 4'b0001, 4'b0010);
    step4("pp6", 2'b10, 4'b0010, 4'b0100);

`ifdef LED_PWM_DIM_EN
    begin
      int lit_cnt;
      duty = 4'd8;
      lit_cnt = 0;
      for (int k = 0; k < 32; k++) begin
        cyc(1'b0, 1'b0, 2'b10);
        check($sformatf("pwm8_%0d", k), 4'b0100, 1'b0);
        if (led_out[2] == 1'b0) lit_cnt++;
      end
      total++;
      if (lit_cnt != 16) begin
        bad++;
        $display("FAIL pwm8_lit_count got=%0d want=16", lit_cnt);
      end
      duty = 4'd0;
      for (int k = 0; k < 16; k++) begin
        cyc(1'b0, 1'b0, 2'b10);
        total++;
        if (led_out !== 4'b1111) begin
          bad++;
          $display("FAIL pwm0_%0d led_out got=%b want=1111", k, led_out);
        end
      end
    end
`endif

    // two-LED, active-high, two-cycle period ping-pong
    cyc2(1'b1, "n2_rst", 2'b01, 1'b0);
    cyc2(1'b0, "n2_c1", 2'b01, 1'b0);
    cyc2(1'b0, "n2_s1", 2'b10, 1'b1);
    cyc2(1'b0, "n2_c2", 2'b10, 1'b0);
    cyc2(1'b0, "n2_s2", 2'b01, 1'b1);
    cyc2(1'b0, "n2_c3", 2'b01, 1'b0);
    cyc2(1'b0, "n2_s3", 2'b10, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
